// File: rtl/axil_reg_slice_if.sv
// rtl/axil_reg_slice_if.sv - AXI4-Lite bundle (AW, W, B, AR, R) with master/slave modports
//
// Purpose: groups the five AXI4-Lite channels of one link into a single bundle.
// Ports (signals), as seen from the master:
//   awaddr/awprot/awvalid out, awready in    write address
//   wdata/wstrb/wvalid    out, wready  in    write data (wstrb is DATA_WIDTH/8)
//   bresp/bvalid          in,  bready  out   write response
//   araddr/arprot/arvalid out, arready in    read address
//   rdata/rresp/rvalid    in,  rready  out   read data
// The slave modport is the mirror image.

interface axil_reg_slice_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input  awready,
      output wdata, wstrb, wvalid,    input  wready,
      input  bresp, bvalid,           output bready,
      output araddr, arprot, arvalid, input  arready,
      input  rdata, rresp, rvalid,    output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid,    output wready,
      output bresp, bvalid,           input  bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid,    input  rready
   );
endinterface

// File: rtl/axil_reg_slice.sv
// rtl/axil_reg_slice.sv - fully registered AXI4-Lite slice (all five channels)
//
// Purpose: breaks every combinational path (valid/payload forward, ready
// backward) between an AXI4-Lite master and slave. Channels are independent;
// beat content and per-channel order are preserved.
// Ports:
//   ACLK     in   clock, rising edge
//   ARESETN  in   synchronous active-low reset
//   s_axil   slave modport  - link from the core (AW/W/AR in, B/R out)
//   m_axil   master modport - link to the bridge (AW/W/AR out, B/R in)
// Build option: AXIL_SLICE_FULL_THROUGHPUT_EN
//   defined   - main + skid register per channel, 1 beat/cycle
//   undefined - main register only, at most 1 beat per 2 cycles

// One channel slice. Source side pushes beats in, sink side pops them out.
module axil_reg_slice_chan #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [WIDTH-1:0] src_data,
   output logic             sink_valid,
   input  logic             sink_ready,
   output logic [WIDTH-1:0] sink_data
);
   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

   state_t           state;
   state_t           state_next;
   logic             push;
   logic             pop;
   logic             load_main;
   logic             ready_next;
   logic [WIDTH-1:0] main_next;

   assign push = src_valid & src_ready;
   assign pop  = sink_valid & sink_ready;

`ifdef AXIL_SLICE_FULL_THROUGHPUT_EN
   logic [WIDTH-1:0] skid_data;
   logic             load_skid;

   always_comb begin
      state_next = state;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      main_next  = src_data;
      unique case (state)
         ST_EMPTY: begin
            if (push) begin
               load_main  = 1'b1;
               state_next = ST_ONE;
            end
         end
         ST_ONE: begin
            if (pop && push) begin
               load_main = 1'b1;
            end else if (pop) begin
               state_next = ST_EMPTY;
            end else if (push) begin
               // sink stalled while the source beat was already in flight
               load_skid  = 1'b1;
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            // ready is low here, so no push can coincide with the pop
            if (pop) begin
               load_main  = 1'b1;
               main_next  = skid_data;
               state_next = ST_ONE;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   assign ready_next = (state_next != ST_FULL);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         skid_data <= '0;
      end else if (load_skid) begin
         skid_data <= src_data;
      end
   end
`else
   always_comb begin
      state_next = state;
      load_main  = 1'b0;
      main_next  = src_data;
      unique case (state)
         ST_EMPTY: begin
            if (push) begin
               load_main  = 1'b1;
               state_next = ST_ONE;
            end
         end
         ST_ONE: begin
            if (pop) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // ready only while the single register is empty: no in-flight beat to absorb
   assign ready_next = (state_next == ST_EMPTY);
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_EMPTY;
         src_ready  <= 1'b0;
         sink_valid <= 1'b0;
         sink_data  <= '0;
      end else begin
         state      <= state_next;
         src_ready  <= ready_next;
         sink_valid <= (state_next != ST_EMPTY);
         if (load_main) begin
            sink_data <= main_next;
         end
      end
   end
endmodule

module axil_reg_slice #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic            ACLK,
   input  logic            ARESETN,
   axil_reg_slice_if.slave  s_axil,
   axil_reg_slice_if.master m_axil
);
   localparam int AW_W = ADDR_WIDTH + 3;
   localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8;
   localparam int B_W  = 2;
   localparam int R_W  = DATA_WIDTH + 2;

   axil_reg_slice_chan #(.WIDTH(AW_W)) u_aw (
      .clk        (ACLK),
      .resetn     (ARESETN),
      .src_valid  (s_axil.awvalid),
      .src_ready  (s_axil.awready),
      .src_data   ({s_axil.awaddr, s_axil.awprot}),
      .sink_valid (m_axil.awvalid),
      .sink_ready (m_axil.awready),
      .sink_data  ({m_axil.awaddr, m_axil.awprot})
   );

   axil_reg_slice_chan #(.WIDTH(W_W)) u_w (
      .clk        (ACLK),
      .resetn     (ARESETN),
      .src_valid  (s_axil.wvalid),
      .src_ready  (s_axil.wready),
      .src_data   ({s_axil.wdata, s_axil.wstrb}),
      .sink_valid (m_axil.wvalid),
      .sink_ready (m_axil.wready),
      .sink_data  ({m_axil.wdata, m_axil.wstrb})
   );

   // response channels flow the other way: the bridge is the source
   axil_reg_slice_chan #(.WIDTH(B_W)) u_b (
      .clk        (ACLK),
      .resetn     (ARESETN),
      .src_valid  (m_axil.bvalid),
      .src_ready  (m_axil.bready),
      .src_data   (m_axil.bresp),
      .sink_valid (s_axil.bvalid),
      .sink_ready (s_axil.bready),
      .sink_data  (s_axil.bresp)
   );

   axil_reg_slice_chan #(.WIDTH(AW_W)) u_ar (
      .clk        (ACLK),
      .resetn     (ARESETN),
      .src_valid  (s_axil.arvalid),
      .src_ready  (s_axil.arready),
      .src_data   ({s_axil.araddr, s_axil.arprot}),
      .sink_valid (m_axil.arvalid),
      .sink_ready (m_axil.arready),
      .sink_data  ({m_axil.araddr, m_axil.arprot})
   );

   axil_reg_slice_chan #(.WIDTH(R_W)) u_r (
      .clk        (ACLK),
      .resetn     (ARESETN),
      .src_valid  (m_axil.rvalid),
      .src_ready  (m_axil.rready),
      .src_data   ({m_axil.rdata, m_axil.rresp}),
      .sink_valid (s_axil.rvalid),
      .sink_ready (s_axil.rready),
      .sink_data  ({s_axil.rdata, s_axil.rresp})
   );
endmodule

// File: tb/tb_axil_reg_slice.sv
// tb/tb_axil_reg_slice.sv - self-checking bench for axil_reg_slice

module tb_axil_reg_slice;
   logic ACLK;
   logic ARESETN;
   int   checks;
   int   errors;

`ifdef AXIL_SLICE_FULL_THROUGHPUT_EN
   localparam int EXP_BUF = 2;
`else
   localparam int EXP_BUF = 1;
`endif

   axil_reg_slice_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
   axil_reg_slice_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

   axil_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .s_axil  (s_if),
      .m_axil  (m_if)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] valids;
      logic [4:0] readys;
      ARESETN = 1'b0;
      s_if.awvalid = 1'b1;
      s_if.awaddr  = 32'hAAAA_0000;
      s_if.awprot  = 3'd5;
      repeat (3) tick();
      @(negedge ACLK);
      valids = {m_if.awvalid, m_if.wvalid, s_if.bvalid, m_if.arvalid, s_if.rvalid};
      readys = {s_if.awready, s_if.wready, m_if.bready, s_if.arready, m_if.rready};
      checks++;
      if (valids !== 5'b0) begin
         errors++;
         $display("FAIL reset_valids: got %b want 00000", valids);
      end
      checks++;
      if (readys !== 5'b0) begin
         errors++;
         $display("FAIL reset_readys: got %b want 00000", readys);
      end
      checks++;
      if ({m_if.awaddr, m_if.wdata, m_if.araddr, s_if.rdata, s_if.bresp, s_if.rresp} !== 132'h0) begin
         errors++;
         $display("FAIL reset_payload: awaddr %h wdata %h araddr %h rdata %h not zero",
                  m_if.awaddr, m_if.wdata, m_if.araddr, s_if.rdata);
      end
      tick();
      ARESETN = 1'b1;
      tick();
      s_if.awvalid = 1'b0;
      @(negedge ACLK);
      readys = {s_if.awready, s_if.wready, m_if.bready, s_if.arready, m_if.rready};
      checks++;
      if (readys !== 5'b11111) begin
         errors++;
         $display("FAIL release_readys: got %b want 11111", readys);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge ACLK);
         checks++;
         if (m_if.awvalid !== 1'b0) begin
            errors++;
            $display("FAIL prereset_aw_leak: cycle %0d m_awvalid %b want 0", c, m_if.awvalid);
         end
      end
   endtask

   task automatic test_single_write();
      logic [31:0] addr_t [2];
      logic [31:0] data_t [2];
      logic [3:0]  strb_t [2];
      logic [1:0]  resp_t [2];
      logic [2:0]  prot_t [2];
      addr_t[0] = 32'h0000_1000; data_t[0] = 32'hDEAD_BEEF; strb_t[0] = 4'hF; resp_t[0] = 2'b00; prot_t[0] = 3'd0;
      addr_t[1] = 32'h0000_2004; data_t[1] = 32'h1234_5678; strb_t[1] = 4'h3; resp_t[1] = 2'b10; prot_t[1] = 3'd1;
      m_if.awready = 1'b1;
      m_if.wready  = 1'b1;
      s_if.bready  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         s_if.awaddr  = addr_t[i];
         s_if.awprot  = prot_t[i];
         s_if.awvalid = 1'b1;
         s_if.wdata   = data_t[i];
         s_if.wstrb   = strb_t[i];
         s_if.wvalid  = 1'b1;
         @(negedge ACLK);
         checks++;
         if ({m_if.awvalid, m_if.wvalid, s_if.awready, s_if.wready} !== 4'b0011) begin
            errors++;
            $display("FAIL wr%0d_pre: m_awv %b m_wv %b s_awr %b s_wr %b want 0 0 1 1", i,
                     m_if.awvalid, m_if.wvalid, s_if.awready, s_if.wready);
         end
         tick();
         s_if.awvalid = 1'b0;
         s_if.wvalid  = 1'b0;
         @(negedge ACLK);
         checks++;
         if ({m_if.awvalid, m_if.awaddr, m_if.awprot} !== {1'b1, addr_t[i], prot_t[i]}) begin
            errors++;
            $display("FAIL wr%0d_aw: valid %b addr %h prot %0d want 1 %h %0d", i,
                     m_if.awvalid, m_if.awaddr, m_if.awprot, addr_t[i], prot_t[i]);
         end
         checks++;
         if ({m_if.wvalid, m_if.wdata, m_if.wstrb} !== {1'b1, data_t[i], strb_t[i]}) begin
            errors++;
            $display("FAIL wr%0d_w: valid %b data %h strb %h want 1 %h %h", i,
                     m_if.wvalid, m_if.wdata, m_if.wstrb, data_t[i], strb_t[i]);
         end
         tick();
         m_if.bvalid = 1'b1;
         m_if.bresp  = resp_t[i];
         @(negedge ACLK);
         checks++;
         if ({m_if.awvalid, m_if.wvalid, s_if.bvalid, m_if.bready} !== 4'b0001) begin
            errors++;
            $display("FAIL wr%0d_mid: m_awv %b m_wv %b s_bv %b m_br %b want 0 0 0 1", i,
                     m_if.awvalid, m_if.wvalid, s_if.bvalid, m_if.bready);
         end
         tick();
         m_if.bvalid = 1'b0;
         @(negedge ACLK);
         checks++;
         if ({s_if.bvalid, s_if.bresp} !== {1'b1, resp_t[i]}) begin
            errors++;
            $display("FAIL wr%0d_b: bvalid %b bresp %0d want 1 %0d", i, s_if.bvalid, s_if.bresp, resp_t[i]);
         end
         tick();
         @(negedge ACLK);
         checks++;
         if (s_if.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr%0d_b_done: bvalid %b want 0", i, s_if.bvalid);
         end
      end
   endtask

   // Streams n AR beats through the slice with a scoreboard on AR and R.
   // m_arready is held low for cycles [st_at, st_at+st_len).
   task automatic run_ar_stream(input int n, input logic [31:0] base, input int st_at, input int st_len,
                                output int first_m, output int last_m, output int acc_stall,
                                output logic rdy_end);
      logic [31:0] exp_ar[$];
      logic [31:0] exp_r[$];
      logic [31:0] br_q[$];
      int   sent;
      int   got_ar;
      int   got_r;
      int   cyc;
      logic s_hs;
      logic m_hs;
      logic r_hs;
      logic mr_hs;
      sent = 0; got_ar = 0; got_r = 0; cyc = 0;
      first_m = -1; last_m = -1; acc_stall = 0; rdy_end = 1'b1;
      tick();
      s_if.araddr  = base;
      s_if.arprot  = 3'd2;
      s_if.arvalid = 1'b1;
      s_if.rready  = 1'b1;
      m_if.arready = !(st_len > 0 && st_at == 0);
      m_if.rvalid  = 1'b0;
      m_if.rresp   = 2'b00;
      m_if.rdata   = 32'h0;
      while ((got_ar < n || got_r < n) && cyc < 300) begin
         @(negedge ACLK);
         s_hs  = s_if.arvalid && s_if.arready;
         m_hs  = m_if.arvalid && m_if.arready;
         r_hs  = s_if.rvalid && s_if.rready;
         mr_hs = m_if.rvalid && m_if.rready;
         if (cyc >= st_at && cyc < st_at + st_len) begin
            if (s_hs) acc_stall++;
            if (cyc == st_at + st_len - 1) rdy_end = s_if.arready;
            if (m_if.arvalid && exp_ar.size() > 0) begin
               checks++;
               if (m_if.araddr !== exp_ar[0]) begin
                  errors++;
                  $display("FAIL ar_stall_stable: cycle %0d araddr %h want %h", cyc, m_if.araddr, exp_ar[0]);
               end
            end
         end
         if (m_hs) begin
            checks++;
            if (exp_ar.size() == 0) begin
               errors++;
               $display("FAIL ar_extra: cycle %0d unexpected beat araddr %h", cyc, m_if.araddr);
            end else begin
               if ({m_if.araddr, m_if.arprot} !== {exp_ar[0], 3'd2}) begin
                  errors++;
                  $display("FAIL ar_order: cycle %0d araddr %h prot %0d want %h 2", cyc,
                           m_if.araddr, m_if.arprot, exp_ar[0]);
               end
               void'(exp_ar.pop_front());
            end
            if (first_m < 0) first_m = cyc;
            last_m = cyc;
            br_q.push_back(32'h100 + got_ar);
            got_ar++;
         end
         if (r_hs) begin
            checks++;
            if (exp_r.size() == 0) begin
               errors++;
               $display("FAIL r_extra: cycle %0d unexpected beat rdata %h", cyc, s_if.rdata);
            end else begin
               if ({s_if.rdata, s_if.rresp} !== {exp_r[0], 2'b00}) begin
                  errors++;
                  $display("FAIL r_order: cycle %0d rdata %h rresp %0d want %h 0", cyc,
                           s_if.rdata, s_if.rresp, exp_r[0]);
               end
               void'(exp_r.pop_front());
            end
            got_r++;
         end
         if (mr_hs) void'(br_q.pop_front());
         if (s_hs) begin
            exp_ar.push_back(base + 32'(4 * sent));
            exp_r.push_back(32'h100 + 32'(sent));
            sent++;
         end
         @(posedge ACLK);
         #1;
         if (s_hs) begin
            if (sent < n) s_if.araddr = base + 32'(4 * sent);
            else s_if.arvalid = 1'b0;
         end
         m_if.arready = !(cyc + 1 >= st_at && cyc + 1 < st_at + st_len);
         m_if.rvalid  = (br_q.size() > 0);
         if (br_q.size() > 0) m_if.rdata = br_q[0];
         cyc++;
      end
      checks++;
      if (got_ar != n || got_r != n || exp_ar.size() != 0) begin
         errors++;
         $display("FAIL stream_complete: ar %0d r %0d pending %0d want %0d %0d 0",
                  got_ar, got_r, exp_ar.size(), n, n);
      end
      s_if.arvalid = 1'b0;
      m_if.rvalid  = 1'b0;
      m_if.arready = 1'b1;
   endtask

   task automatic test_back_to_back();
      int   first_m, last_m, acc;
      logic rdy;
      run_ar_stream(8, 32'h0, 0, 0, first_m, last_m, acc, rdy);
      checks++;
      if (first_m != 1) begin
         errors++;
         $display("FAIL b2b_latency: first M_AR beat cycle %0d want 1", first_m);
      end
`ifdef AXIL_SLICE_FULL_THROUGHPUT_EN
      checks++;
      if (last_m - first_m != 7) begin
         errors++;
         $display("FAIL b2b_throughput: 8 beats spanned %0d cycles want 8", last_m - first_m + 1);
      end
`endif
   endtask

   task automatic test_backpressure();
      int   first_m, last_m, acc;
      logic rdy;
      run_ar_stream(6, 32'h40, 0, 5, first_m, last_m, acc, rdy);
      checks++;
      if (acc != EXP_BUF) begin
         errors++;
         $display("FAIL bp_buffered: %0d beats accepted while stalled want %0d", acc, EXP_BUF);
      end
      checks++;
      if (rdy !== 1'b0) begin
         errors++;
         $display("FAIL bp_ready_low: s_arready %b at stall end want 0", rdy);
      end
      checks++;
      if (first_m != 5) begin
         errors++;
         $display("FAIL bp_release: first M_AR beat cycle %0d want 5", first_m);
      end
   endtask

   task automatic test_push_pop_full();
      int   first_m, last_m, acc;
      logic rdy;
      run_ar_stream(6, 32'h80, 2, 3, first_m, last_m, acc, rdy);
      checks++;
      if (rdy !== 1'b0) begin
         errors++;
         $display("FAIL pp_ready_low: s_arready %b at stall end want 0", rdy);
      end
`ifdef AXIL_SLICE_FULL_THROUGHPUT_EN
      checks++;
      if (first_m != 1 || last_m != 9) begin
         errors++;
         $display("FAIL pp_throughput: M_AR beats cycles %0d..%0d want 1..9", first_m, last_m);
      end
`endif
   endtask

   task automatic test_reset_mid_stall();
      int   acc;
      logic hs;
      int   first_m, last_m, acc2;
      logic rdy;
      tick();
      m_if.arready = 1'b0;
      s_if.araddr  = 32'h0000_BAD0;
      s_if.arprot  = 3'd0;
      s_if.arvalid = 1'b1;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge ACLK);
         hs = s_if.arvalid && s_if.arready;
         tick();
         if (hs) begin
            acc++;
            s_if.araddr = 32'h0000_BAD0 + 32'(4 * acc);
         end
      end
      s_if.arvalid = 1'b0;
      @(negedge ACLK);
      checks++;
      if (acc != EXP_BUF || m_if.arvalid !== 1'b1 || s_if.arready !== 1'b0) begin
         errors++;
         $display("FAIL rst_stall_fill: accepted %0d m_arvalid %b s_arready %b want %0d 1 0",
                  acc, m_if.arvalid, s_if.arready, EXP_BUF);
      end
      tick();
      ARESETN = 1'b0;
      m_if.arready = 1'b1;
      tick();
      ARESETN = 1'b1;
      @(negedge ACLK);
      checks++;
      if ({m_if.arvalid, s_if.arready} !== 2'b00) begin
         errors++;
         $display("FAIL rst_stall_clear: m_arvalid %b s_arready %b want 0 0", m_if.arvalid, s_if.arready);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge ACLK);
         checks++;
         if (m_if.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_leak: cycle %0d m_arvalid %b araddr %h want 0", c, m_if.arvalid, m_if.araddr);
         end
      end
      run_ar_stream(2, 32'h200, 0, 0, first_m, last_m, acc2, rdy);
      checks++;
      if (first_m != 1) begin
         errors++;
         $display("FAIL rst_recover: first M_AR beat cycle %0d want 1", first_m);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ARESETN = 1'b0;
      s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = 1'b0;
      s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 1'b0;
      s_if.bready = 1'b0;
      s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = 1'b0;
      s_if.rready = 1'b0;
      m_if.awready = 1'b0; m_if.wready = 1'b0;
      m_if.bresp = '0; m_if.bvalid = 1'b0;
      m_if.arready = 1'b0;
      m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 1'b0;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_backpressure();
      test_push_pop_full();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
